// File: rtl/mem_dma.sv
`timescale 1ns/1ps
// mem_dma: single-channel word copy engine. Reads a word, writes it back out, and repeats
// over a simple valid/ready bus, with abort, misalignment and per-transaction timeout handling.
module mem_dma #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, GAP, FIN} state_t;

    state_t      state_q;
    logic [31:0] src_q, dst_q, data_q, addr_q, wdata_q, tmo_q;
    logic [15:0] len_q, words_q;
    logic [3:0]  wstrb_q;
    logic        valid_q, error_q, abort_q;

    logic [31:0] src_d, dst_d;
    logic [15:0] words_d;
    logic        tmo_hit_d, stop_d;

    always_comb begin
        src_d     = src_q + 32'd4;
        dst_d     = dst_q + 32'd4;
        words_d   = words_q + 16'd1;
        tmo_hit_d = (TIMEOUT != 0) && (tmo_q == TIMEOUT - 1);
        stop_d    = (words_q == len_q) || abort_q || abort;
    end

    // The held write strobe doubles as the read/write phase marker while in GAP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            abort_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= len;
                        words_q <= '0;
                        error_q <= 1'b0;
                        abort_q <= 1'b0;
                        if (len == 16'd0) begin
                            state_q <= FIN;
                        end else if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                            error_q <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            valid_q <= 1'b1;
                            addr_q  <= src_addr;
                            wstrb_q <= 4'h0;
                            tmo_q   <= '0;
                            state_q <= READ;
                        end
                    end
                end
                READ, WRITE: begin
                    if (abort) abort_q <= 1'b1;
                    if (mem_ready) begin
                        valid_q <= 1'b0;
                        state_q <= GAP;
                        if (state_q == READ) begin
                            data_q <= mem_rdata;
                            src_q  <= src_d;
                        end else begin
                            dst_q   <= dst_d;
                            words_q <= words_d;
                        end
                    end else if (tmo_hit_d) begin
                        valid_q <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                GAP: begin
                    if (abort) abort_q <= 1'b1;
                    if (wstrb_q == 4'h0) begin
                        valid_q <= 1'b1;
                        addr_q  <= dst_q;
                        wdata_q <= data_q;
                        wstrb_q <= 4'hF;
                        tmo_q   <= '0;
                        state_q <= WRITE;
                    end else if (stop_d) begin
                        state_q <= FIN;
                    end else begin
                        valid_q <= 1'b1;
                        addr_q  <= src_q;
                        wstrb_q <= 4'h0;
                        tmo_q   <= '0;
                        state_q <= READ;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign error      = error_q;
    assign words_done = words_q;
    assign mem_valid  = valid_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_dma.sv
`timescale 1ns/1ps
// Bench for mem_dma: bus responder with a word-addressed memory model, protocol monitor,
// and directed plus randomized copies checked against expected word lists.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, error, mem_valid;
    logic [15:0] words_done;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_dma #(.TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error), .words_done(words_done),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int unsigned tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: preloaded words, otherwise a seeded hash of the address.
    logic [31:0] rd_mem [bit [31:0]];
    logic [31:0] seed = 32'h1234_5678;
    function automatic logic [31:0] src_word(input logic [31:0] a);
        if (rd_mem.exists(a)) return rd_mem[a];
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    int          resp_mode = 0;   // 0 random latency, 1 never ready, 2 fixed 5-cycle stall
    bit          spurious_en = 1'b1;
    int          done_cnt = 0, req_cnt = 0, read_cnt = 0, valid_cycles = 0;
    bit          armed = 1'b0;
    int unsigned wait_left = 0;
    logic        pv_valid = 1'b0, pv_ready = 1'b0, pv_done = 1'b0, hs_prev = 1'b0, hs_now;
    logic [31:0] pv_addr = '0, pv_wdata = '0;
    logic [3:0]  pv_wstrb = '0;

    // Monitor first (sees what the DUT sampled last edge), then the responder drives.
    always @(negedge clk) begin
        hs_now = pv_valid && pv_ready;
        if (resetn) begin
            if (done) begin
                done_cnt++;
                check("done_single", {31'b0, pv_done}, 32'd0);
            end
            if (mem_valid) valid_cycles++;
            if (mem_valid && !pv_valid) begin
                req_cnt++;
                if (mem_wstrb == 4'h0) read_cnt++;
            end
            if (pv_valid && !pv_ready && mem_valid) begin
                check("hold_addr", mem_addr, pv_addr);
                check("hold_wdata", mem_wdata, pv_wdata);
                check("hold_wstrb", {28'b0, mem_wstrb}, {28'b0, pv_wstrb});
            end
            if (hs_now) check("drop_after_ready", {31'b0, mem_valid}, 32'd0);
            if (hs_prev) check("one_gap", {31'b0, mem_valid}, {31'b0, !done});
        end
        hs_prev = hs_now && resetn;

        if (mem_ready) begin
            mem_ready = 1'b0;
            armed = 1'b0;
        end else if (mem_valid) begin
            if (!armed) begin
                armed = 1'b1;
                wait_left = (resp_mode == 2) ? 5 : $urandom_range(3, 0);
            end
            if (resp_mode != 1) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'hF) begin
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        mem_rdata = src_word(mem_addr);
                    end
                end else begin
                    wait_left--;
                end
            end
        end else begin
            armed = 1'b0;
            if (spurious_en && ($urandom_range(3, 0) == 0)) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end
        end
        pv_valid = mem_valid; pv_ready = mem_ready; pv_done = done;
        pv_addr = mem_addr; pv_wdata = mem_wdata; pv_wstrb = mem_wstrb;
    end

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int abort_k, input string tag);
        int done0, req0, rd0, exp_n, c;
        bit exp_err;
        exp_err = (n != 0) && ((s[1:0] != 2'b00) || (d[1:0] != 2'b00));
        if (exp_err) exp_n = 0;
        else if (abort_k > 0 && abort_k < int'(n)) exp_n = abort_k;
        else exp_n = int'(n);
        wr_addr_q.delete();
        wr_data_q.delete();
        done0 = done_cnt; req0 = req_cnt; rd0 = read_cnt;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (n == 0 || exp_err) check({tag, "_done_next"}, {31'b0, done}, 32'd1);
        if (abort_k > 0) begin
            c = 0;
            while ((read_cnt - rd0) < abort_k && c < 2000) begin
                @(negedge clk); #1; c++;
            end
            abort = 1'b1;
            @(negedge clk); #1;
            abort = 1'b0;
        end
        c = 0;
        while (done_cnt == done0 && c < 3000) begin
            @(negedge clk); #1; c++;
        end
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_done_cnt"}, done_cnt - done0, 32'd1);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
        check({tag, "_words"}, {16'b0, words_done}, exp_n);
        check({tag, "_nwrites"}, wr_addr_q.size(), exp_n);
        check({tag, "_reqs"}, req_cnt - req0, 2 * exp_n);
        check({tag, "_reads"}, read_cnt - rd0, exp_n);
        for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
            check({tag, "_waddr"}, wr_addr_q[i], d + 32'(4 * i));
            check({tag, "_wdata"}, wr_data_q[i], src_word(s + 32'(4 * i)));
        end
    endtask

    initial begin
        int done0, req0, vc0, c;
        bit found;
        #1 resetn = 1'b0;
        #2;
        check("rst_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_words", {16'b0, words_done}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        rd_mem[32'h100] = 32'hAAAA_0001;
        rd_mem[32'h104] = 32'hBBBB_0002;
        rd_mem[32'h108] = 32'hCCCC_0003;
        run_xfer(32'h100, 32'h200, 16'd3, 0, "basic");
        run_xfer(32'h40, 32'h80, 16'd0, 0, "len0");

        // start held into FIN must not re-trigger
        done0 = done_cnt;
        @(negedge clk);
        len = 16'd0; start = 1'b1;
        @(negedge clk); #1;
        check("finstart_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("finstart_idle", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("finstart_cnt", done_cnt - done0, 32'd1);

        run_xfer(32'h102, 32'h200, 16'd2, 0, "mis_src");
        check("err_sticky", {31'b0, error}, 32'd1);
        run_xfer(32'h100, 32'h201, 16'd2, 0, "mis_dst");
        run_xfer(32'h1000, 32'h2000, 16'd8, 3, "abort3");

        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        run_xfer(32'h1100, 32'h2100, 16'd4, 0, "idle_abort");
        run_xfer(32'hFFFF_FFF8, 32'h3000, 16'd3, 0, "wrap");

        for (int r = 0; r < 6; r++) begin
            logic [31:0] s, d;
            logic [15:0] n;
            int k;
            seed = $urandom;
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            n = 16'($urandom_range(6, 1));
            k = ($urandom_range(1, 0) == 1) ? int'($urandom_range(32'(n), 1)) : 0;
            run_xfer(s, d, n, k, "rand");
        end

        // timeout: responder never answers
        resp_mode = 1;
        done0 = done_cnt; req0 = req_cnt; vc0 = valid_cycles;
        wr_addr_q.delete();
        @(negedge clk);
        src_addr = 32'h500; dst_addr = 32'h600; len = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (done_cnt == done0 && c < 200) begin
            @(negedge clk); #1; c++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("tmo_cycles", valid_cycles - vc0, 32'd16);
        check("tmo_error", {31'b0, error}, 32'd1);
        check("tmo_done", done_cnt - done0, 32'd1);
        check("tmo_reqs", req_cnt - req0, 32'd1);
        check("tmo_words", {16'b0, words_done}, 32'd0);
        check("tmo_nwrites", wr_addr_q.size(), 32'd0);
        resp_mode = 0;

        // stalled responder, then asynchronous reset in the middle of a write
        resp_mode = 2;
        spurious_en = 1'b0;
        wr_addr_q.delete();
        @(negedge clk);
        src_addr = 32'h700; dst_addr = 32'h800; len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        c = 0;
        while (!found && c < 500) begin
            @(negedge clk); #1; c++;
            found = mem_valid && (mem_wstrb == 4'hF);
        end
        check("stall_write_seen", {31'b0, found}, 32'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        done0 = done_cnt;
        check("arst_valid", {31'b0, mem_valid}, 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_error", {31'b0, error}, 32'd0);
        check("arst_words", {16'b0, words_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("arst_no_done", done_cnt - done0, 32'd0);
        check("arst_idle", {31'b0, busy}, 32'd0);
        check("arst_nwrites", wr_addr_q.size(), 32'd0);
        resp_mode = 0;
        spurious_en = 1'b1;

        run_xfer(32'h900, 32'hA00, 16'd2, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
